// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 set-2 scan-code decoder.
package ps2_pkg;

    // Prefix-tracking states of the decoder FSM.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } ps2_state_t;

    // Set-2 prefix bytes.
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;

    // Shift keys (non-extended codes).
    localparam logic [7:0] PS2_LSHIFT = 8'h12;
    localparam logic [7:0] PS2_RSHIFT = 8'h59;

    // Keyboard error / overrun bytes, never a key.
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    // True for left or right shift. E0 12 appears inside the extended
    // print-screen sequence and is not a real shift, so ext must be 0.
    function automatic logic is_shift(input logic [7:0] code, input logic ext);
        return !ext && ((code == PS2_LSHIFT) || (code == PS2_RSHIFT));
    endfunction

endpackage

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 scan code to ASCII lookup. Only non-extended
// letters, digits, space and enter are mapped; everything else is 00.
module ps2_ascii_lut (
    input  logic [7:0] code,
    input  logic       ext,
    input  logic       shift,
    output logic [7:0] ascii
);

    logic [7:0] lower;
    logic       is_letter;

    // Base (unshifted) character for the code.
    always_comb begin
        lower = 8'h00;
        if (!ext) begin
            case (code)
                8'h1C: lower = 8'h61; // a
                8'h32: lower = 8'h62; // b
                8'h21: lower = 8'h63; // c
                8'h23: lower = 8'h64; // d
                8'h24: lower = 8'h65; // e
                8'h2B: lower = 8'h66; // f
                8'h34: lower = 8'h67; // g
                8'h33: lower = 8'h68; // h
                8'h43: lower = 8'h69; // i
                8'h3B: lower = 8'h6A; // j
                8'h42: lower = 8'h6B; // k
                8'h4B: lower = 8'h6C; // l
                8'h3A: lower = 8'h6D; // m
                8'h31: lower = 8'h6E; // n
                8'h44: lower = 8'h6F; // o
                8'h4D: lower = 8'h70; // p
                8'h15: lower = 8'h71; // q
                8'h2D: lower = 8'h72; // r
                8'h1B: lower = 8'h73; // s
                8'h2C: lower = 8'h74; // t
                8'h3C: lower = 8'h75; // u
                8'h2A: lower = 8'h76; // v
                8'h1D: lower = 8'h77; // w
                8'h22: lower = 8'h78; // x
                8'h35: lower = 8'h79; // y
                8'h1A: lower = 8'h7A; // z
                8'h45: lower = 8'h30; // 0
                8'h16: lower = 8'h31; // 1
                8'h1E: lower = 8'h32; // 2
                8'h26: lower = 8'h33; // 3
                8'h25: lower = 8'h34; // 4
                8'h2E: lower = 8'h35; // 5
                8'h36: lower = 8'h36; // 6
                8'h3D: lower = 8'h37; // 7
                8'h3E: lower = 8'h38; // 8
                8'h46: lower = 8'h39; // 9
                8'h29: lower = 8'h20; // space
                8'h5A: lower = 8'h0D; // enter
                default: lower = 8'h00;
            endcase
        end
    end

    // Shift only upper-cases letters; digits keep their plain value.
    always_comb begin
        is_letter = (lower >= 8'h61) && (lower <= 8'h7A);
        ascii     = (is_letter && shift) ? (lower - 8'h20) : lower;
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Consumer of the ps2_keyboard FIFO: pops raw set-2 bytes, folds the E0/F0
// prefixes into single make/break events and tracks held key, shift state
// and a new-press counter. Clears the receiver on FIFO overflow.
//
// Handshake with ps2_keyboard: a byte is taken on a clk edge where
// kb_ready=1, kb_nextdata_n=1 and kb_overflow=0. In the following cycle
// kb_nextdata_n is low for exactly one cycle (the FIFO pops on the edge
// that ends it) and no byte is taken while it is low, so every byte gets
// exactly one pop and at most one byte is taken per two cycles.
// Overflow wins over acceptance.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int PCNT_W = 8
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [7:0]        kb_data,
    input  logic              kb_ready,
    input  logic              kb_overflow,
    output logic              kb_nextdata_n,
    output logic              kb_clrn,
    output logic              evt_valid,
    output logic              evt_break,
    output logic              evt_repeat,
    output logic [7:0]        key_code,
    output logic              key_ext,
    output logic              key_down,
    output logic              shift_held,
    output logic [7:0]        ascii,
    output logic [PCNT_W-1:0] press_count,
    output logic              ovf_seen,
    output ps2_state_t        state_dbg
);

    ps2_state_t        state, state_nxt;

    logic              accept;
    logic              do_make, do_break, ev_ext;

    logic              nextdata_n_nxt, clrn_nxt;
    logic              evt_valid_nxt, evt_break_nxt, evt_repeat_nxt;
    logic [7:0]        key_code_nxt;
    logic              key_ext_nxt, key_down_nxt, shift_held_nxt, ovf_seen_nxt;
    logic [PCNT_W-1:0] press_count_nxt;

    // Held key: the code of the last new make, used to decide if a break
    // releases the key that key_down refers to.
    logic [7:0]        held_code, held_code_nxt;
    logic              held_ext, held_ext_nxt;

    assign accept    = kb_ready && kb_nextdata_n && !kb_overflow;
    assign state_dbg = state;

    // FSM state register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            kb_nextdata_n <= 1'b1;
            kb_clrn       <= 1'b0;
            evt_valid     <= 1'b0;
            evt_break     <= 1'b0;
            evt_repeat    <= 1'b0;
            key_code      <= 8'h00;
            key_ext       <= 1'b0;
            key_down      <= 1'b0;
            shift_held    <= 1'b0;
            press_count   <= '0;
            ovf_seen      <= 1'b0;
            held_code     <= 8'h00;
            held_ext      <= 1'b0;
        end else begin
            kb_nextdata_n <= nextdata_n_nxt;
            kb_clrn       <= clrn_nxt;
            evt_valid     <= evt_valid_nxt;
            evt_break     <= evt_break_nxt;
            evt_repeat    <= evt_repeat_nxt;
            key_code      <= key_code_nxt;
            key_ext       <= key_ext_nxt;
            key_down      <= key_down_nxt;
            shift_held    <= shift_held_nxt;
            press_count   <= press_count_nxt;
            ovf_seen      <= ovf_seen_nxt;
            held_code     <= held_code_nxt;
            held_ext      <= held_ext_nxt;
        end
    end

    // Next-state, event decode and tracking updates.
    always_comb begin
        state_nxt       = state;
        nextdata_n_nxt  = !accept;
        clrn_nxt        = 1'b1;
        evt_valid_nxt   = 1'b0;
        evt_break_nxt   = 1'b0;
        evt_repeat_nxt  = 1'b0;
        key_code_nxt    = key_code;
        key_ext_nxt     = key_ext;
        key_down_nxt    = key_down;
        shift_held_nxt  = shift_held;
        press_count_nxt = press_count;
        ovf_seen_nxt    = ovf_seen;
        held_code_nxt   = held_code;
        held_ext_nxt    = held_ext;
        do_make         = 1'b0;
        do_break        = 1'b0;
        ev_ext          = 1'b0;

        if (kb_overflow) begin
            // Lost bytes make the prefix context and held-key view
            // untrustworthy: restart clean but keep count and last code.
            clrn_nxt       = !kb_clrn;
            state_nxt      = S_IDLE;
            key_down_nxt   = 1'b0;
            shift_held_nxt = 1'b0;
            ovf_seen_nxt   = 1'b1;
        end else if (accept) begin
            if ((kb_data == PS2_ERR0) || (kb_data == PS2_ERR1)) begin
                state_nxt = S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (kb_data == PS2_EXT)      state_nxt = S_EXT;
                        else if (kb_data == PS2_BRK) state_nxt = S_BRK;
                        else                         do_make   = 1'b1;
                    end
                    S_EXT: begin
                        // A repeated E0 is still only a prefix.
                        if (kb_data == PS2_BRK)      state_nxt = S_EXT_BRK;
                        else if (kb_data != PS2_EXT) begin
                            do_make = 1'b1;
                            ev_ext  = 1'b1;
                        end
                    end
                    S_BRK: begin
                        // E0 after F0 is out of order: restart as extended.
                        if (kb_data == PS2_EXT)      state_nxt = S_EXT;
                        else if (kb_data != PS2_BRK) do_break  = 1'b1;
                    end
                    S_EXT_BRK: begin
                        if (kb_data == PS2_EXT)      state_nxt = S_EXT;
                        else if (kb_data != PS2_BRK) begin
                            do_break = 1'b1;
                            ev_ext   = 1'b1;
                        end
                    end
                    default: state_nxt = S_IDLE;
                endcase
            end
        end

        if (do_make) begin
            state_nxt     = S_IDLE;
            evt_valid_nxt = 1'b1;
            key_code_nxt  = kb_data;
            key_ext_nxt   = ev_ext;
            // Typematic repeat: same key as the last event while still down.
            if (key_down && (key_ext == ev_ext) && (key_code == kb_data)) begin
                evt_repeat_nxt = 1'b1;
            end else begin
                press_count_nxt = press_count + PCNT_W'(1);
                key_down_nxt    = 1'b1;
                held_code_nxt   = kb_data;
                held_ext_nxt    = ev_ext;
            end
            if (is_shift(kb_data, ev_ext)) shift_held_nxt = 1'b1;
        end

        if (do_break) begin
            state_nxt     = S_IDLE;
            evt_valid_nxt = 1'b1;
            evt_break_nxt = 1'b1;
            key_code_nxt  = kb_data;
            key_ext_nxt   = ev_ext;
            // Releasing some other key leaves the held key down.
            if ((held_code == kb_data) && (held_ext == ev_ext)) key_down_nxt = 1'b0;
            if (is_shift(kb_data, ev_ext)) shift_held_nxt = 1'b0;
        end
    end

    ps2_ascii_lut u_ascii_lut (
        .code  (key_code),
        .ext   (key_ext),
        .shift (shift_held),
        .ascii (ascii)
    );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: a table of byte-by-byte
// expectations plus hand-written overflow, wrap and mid-stream reset cases.
module tb_ps2_scancode_decoder;
    import ps2_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       kb_overflow;
    logic       kb_nextdata_n;
    logic       kb_clrn;
    logic       evt_valid;
    logic       evt_break;
    logic       evt_repeat;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_down;
    logic       shift_held;
    logic [7:0] ascii;
    logic [7:0] press_count;
    logic       ovf_seen;
    ps2_state_t state_dbg;

    always #5 clk = ~clk;

    ps2_scancode_decoder #(.PCNT_W(8)) dut (
        .clk           (clk),
        .clrn          (clrn),
        .kb_data       (kb_data),
        .kb_ready      (kb_ready),
        .kb_overflow   (kb_overflow),
        .kb_nextdata_n (kb_nextdata_n),
        .kb_clrn       (kb_clrn),
        .evt_valid     (evt_valid),
        .evt_break     (evt_break),
        .evt_repeat    (evt_repeat),
        .key_code      (key_code),
        .key_ext       (key_ext),
        .key_down      (key_down),
        .shift_held    (shift_held),
        .ascii         (ascii),
        .press_count   (press_count),
        .ovf_seen      (ovf_seen),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pop-strobe monitor: counts pops and flags any low pulse longer than a cycle.
    int   pop_cnt   = 0;
    int   width_err = 0;
    logic prev_n    = 1'b1;
    always @(posedge clk) begin
        if (!kb_nextdata_n) begin
            pop_cnt++;
            if (!prev_n) width_err++;
        end
        prev_n = kb_nextdata_n;
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic [2:0] vbr;   // {evt_valid, evt_break, evt_repeat}
        logic [7:0] code;
        logic [2:0] eds;   // {key_ext, key_down, shift_held}
        logic [7:0] asc;
        logic [7:0] pc;
    } vec_t;
    vec_t vq[$];

    task automatic add(input logic [7:0] d, input logic [2:0] vbr, input logic [7:0] code,
                       input logic [2:0] eds, input logic [7:0] asc, input logic [7:0] pc);
        vec_t v;
        v.data = d; v.vbr = vbr; v.code = code; v.eds = eds; v.asc = asc; v.pc = pc;
        vq.push_back(v);
    endtask

    // ---------------- driver ----------------
    // Presents one byte for one edge, then idles through the pop cycle.
    task automatic send_byte(input logic [7:0] b);
        kb_data  = b;
        kb_ready = 1'b1;
        @(posedge clk); #1;
        kb_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- test ----------------
    initial begin
        int         pop0;
        int         evs;
        logic       found;
        logic       pend;
        logic [7:0] fq[$];

        // make 1C, break 1C
        add(8'h1C, 3'b100, 8'h1C, 3'b010, 8'h61, 8'd1);
        add(8'hF0, 3'b000, 8'h1C, 3'b010, 8'h61, 8'd1);
        add(8'h1C, 3'b110, 8'h1C, 3'b000, 8'h61, 8'd1);
        // typematic repeats
        add(8'h1C, 3'b100, 8'h1C, 3'b010, 8'h61, 8'd2);
        add(8'h1C, 3'b101, 8'h1C, 3'b010, 8'h61, 8'd2);
        add(8'h1C, 3'b101, 8'h1C, 3'b010, 8'h61, 8'd2);
        add(8'hF0, 3'b000, 8'h1C, 3'b010, 8'h61, 8'd2);
        add(8'h1C, 3'b110, 8'h1C, 3'b000, 8'h61, 8'd2);
        // extended make / break
        add(8'hE0, 3'b000, 8'h1C, 3'b000, 8'h61, 8'd2);
        add(8'h75, 3'b100, 8'h75, 3'b110, 8'h00, 8'd3);
        add(8'hE0, 3'b000, 8'h75, 3'b110, 8'h00, 8'd3);
        add(8'hF0, 3'b000, 8'h75, 3'b110, 8'h00, 8'd3);
        add(8'h75, 3'b110, 8'h75, 3'b100, 8'h00, 8'd3);
        // shifted letter
        add(8'h12, 3'b100, 8'h12, 3'b011, 8'h00, 8'd4);
        add(8'h1C, 3'b100, 8'h1C, 3'b011, 8'h41, 8'd5);
        add(8'hF0, 3'b000, 8'h1C, 3'b011, 8'h41, 8'd5);
        add(8'h1C, 3'b110, 8'h1C, 3'b001, 8'h41, 8'd5);
        add(8'hF0, 3'b000, 8'h1C, 3'b001, 8'h41, 8'd5);
        add(8'h12, 3'b110, 8'h12, 3'b000, 8'h00, 8'd5);
        // digit, error bytes, space, enter, z
        add(8'h45, 3'b100, 8'h45, 3'b010, 8'h30, 8'd6);
        add(8'hF0, 3'b000, 8'h45, 3'b010, 8'h30, 8'd6);
        add(8'h00, 3'b000, 8'h45, 3'b010, 8'h30, 8'd6);
        add(8'h29, 3'b100, 8'h29, 3'b010, 8'h20, 8'd7);
        add(8'h5A, 3'b100, 8'h5A, 3'b010, 8'h0D, 8'd8);
        add(8'hFF, 3'b000, 8'h5A, 3'b010, 8'h0D, 8'd8);
        add(8'h1A, 3'b100, 8'h1A, 3'b010, 8'h7A, 8'd9);
        // right shift, shifted z, release of a non-held key
        add(8'h59, 3'b100, 8'h59, 3'b011, 8'h00, 8'd10);
        add(8'h1A, 3'b100, 8'h1A, 3'b011, 8'h5A, 8'd11);
        add(8'hF0, 3'b000, 8'h1A, 3'b011, 8'h5A, 8'd11);
        add(8'h59, 3'b110, 8'h59, 3'b010, 8'h00, 8'd11);

        // reset state
        clrn = 1'b0; kb_ready = 1'b0; kb_overflow = 1'b0; kb_data = 8'h00;
        #12;
        chk("rst.nextdata_n", kb_nextdata_n, 1'b1);
        chk("rst.kb_clrn", kb_clrn, 1'b0);
        chk("rst.evt_valid", evt_valid, 1'b0);
        chk("rst.key_code", key_code, 8'h00);
        chk("rst.key_down", key_down, 1'b0);
        chk("rst.press_count", press_count, 8'd0);
        chk("rst.ovf_seen", ovf_seen, 1'b0);
        chk("rst.ascii", ascii, 8'h00);
        chk("rst.state", state_dbg, S_IDLE);
        clrn = 1'b1;
        @(posedge clk); #1;
        chk("rel.kb_clrn", kb_clrn, 1'b1);

        // table
        pop0 = pop_cnt;
        for (int i = 0; i < vq.size(); i++) begin
            kb_data  = vq[i].data;
            kb_ready = 1'b1;
            @(posedge clk); #1;
            chk($sformatf("v%0d.nextdata_n", i), kb_nextdata_n, 1'b0);
            chk($sformatf("v%0d.vbr", i), {evt_valid, evt_break, evt_repeat}, vq[i].vbr);
            chk($sformatf("v%0d.key_code", i), key_code, vq[i].code);
            chk($sformatf("v%0d.ext_down_shift", i), {key_ext, key_down, shift_held}, vq[i].eds);
            chk($sformatf("v%0d.ascii", i), ascii, vq[i].asc);
            chk($sformatf("v%0d.press_count", i), press_count, vq[i].pc);
            kb_ready = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("v%0d.evt_clear", i), evt_valid, 1'b0);
        end
        chk("table.pops", pop_cnt - pop0, vq.size());

        // press_count wrap: 256 alternating new presses
        for (int i = 0; i < 256; i++) begin
            send_byte((i % 2 == 0) ? 8'h32 : 8'h1C);
            if (i == 244) chk("wrap.zero", press_count, 8'd0);
        end
        chk("wrap.full", press_count, 8'd11);

        // overflow after F0, with a byte waiting
        send_byte(8'h12);
        kb_data = 8'hF0; kb_ready = 1'b1;
        @(posedge clk); #1;
        chk("ovf.pre_state", state_dbg, S_BRK);
        kb_ready = 1'b0;
        @(posedge clk); #1;
        kb_data = 8'h1C; kb_ready = 1'b1; kb_overflow = 1'b1;
        @(posedge clk); #1;
        chk("ovf.kb_clrn", kb_clrn, 1'b0);
        chk("ovf.ovf_seen", ovf_seen, 1'b1);
        chk("ovf.state", state_dbg, S_IDLE);
        chk("ovf.key_down", key_down, 1'b0);
        chk("ovf.shift", shift_held, 1'b0);
        chk("ovf.no_event", evt_valid, 1'b0);
        chk("ovf.no_pop", kb_nextdata_n, 1'b1);
        chk("ovf.press_count", press_count, 8'd12);
        chk("ovf.key_code", key_code, 8'h12);
        kb_overflow = 1'b0; kb_ready = 1'b0;
        @(posedge clk); #1;
        chk("ovf.kb_clrn_back", kb_clrn, 1'b1);
        kb_data = 8'h1C; kb_ready = 1'b1;
        @(posedge clk); #1;
        chk("ovf.next_vbr", {evt_valid, evt_break, evt_repeat}, 3'b100);
        chk("ovf.next_down", key_down, 1'b1);
        chk("ovf.next_ascii", ascii, 8'h61);
        chk("ovf.next_pc", press_count, 8'd13);
        kb_ready = 1'b0;
        @(posedge clk); #1;

        // kb_ready held high over queued bytes, reset after E0
        fq = '{8'h32, 8'h1C, 8'hE0, 8'h75};
        pop0 = pop_cnt; evs = 0; found = 1'b0; pend = 1'b0;
        kb_data = fq[0]; kb_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1;
            if (pend) begin
                fq.delete(0);
                kb_data = fq[0];
            end
            pend = !kb_nextdata_n;
            if (evt_valid) evs++;
            if (state_dbg == S_EXT) found = 1'b1;
        end
        chk("stream.reached_ext", found, 1'b1);
        chk("stream.events", evs, 2);
        chk("stream.pops", pop_cnt - pop0, 2);
        chk("stream.press_count", press_count, 8'd15);
        #3 clrn = 1'b0;
        #1;
        chk("arst.nextdata_n", kb_nextdata_n, 1'b1);
        chk("arst.kb_clrn", kb_clrn, 1'b0);
        chk("arst.state", state_dbg, S_IDLE);
        chk("arst.press_count", press_count, 8'd0);
        chk("arst.key_code", key_code, 8'h00);
        chk("arst.ovf_seen", ovf_seen, 1'b0);
        chk("arst.evt_valid", evt_valid, 1'b0);
        kb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 clrn = 1'b1;
        @(posedge clk); #1;
        chk("arst.kb_clrn_back", kb_clrn, 1'b1);
        chk("arst.no_event", evt_valid, 1'b0);
        chk("pop.width", width_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
